// File: rtl/voting_machine_param.sv
// voting_machine_param
//   Poll-session voting machine. Accepts one vote per unique voter while a
//   poll is open, keeps a saturating tally per candidate and, once the poll
//   closes, scans the tallies one candidate per cycle to report the winner,
//   a tie flag and the number of accepted votes.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset; votes nacked, waiting for open_poll
//   OPEN  | session running; votes checked, acked/nacked, tallied
//   TALLY | sequential max scan, one candidate per cycle (NUM_CAND cycles)
//   DONE  | result held (winner_valid=1) until the next open_poll or rst
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   open_poll, close_poll    session control pulses
//   vote_valid/cand/voter_id vote strobe, candidate index, voter ID
//   vote_ack, vote_nack      registered one-cycle accept/reject pulses
//   state                    00 IDLE, 01 OPEN, 10 TALLY, 11 DONE
//   winner, winner_valid     result index, valid while in DONE
//   tie                      more than one candidate holds the max (DONE)
//   total_votes              accepted votes of current/last session
module voting_machine_param #(
  parameter int NUM_CAND   = 8,
  parameter int CAND_W     = 3,
  parameter int NUM_VOTERS = 16,
  parameter int VOTER_W    = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               open_poll,
  input  logic               close_poll,
  input  logic               vote_valid,
  input  logic [CAND_W-1:0]  vote_cand,
  input  logic [VOTER_W-1:0] voter_id,
  output logic               vote_ack,
  output logic               vote_nack,
  output logic [1:0]         state,
  output logic [CAND_W-1:0]  winner,
  output logic               winner_valid,
  output logic               tie,
  output logic [VOTER_W:0]   total_votes
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_OPEN  = 2'b01,
    S_TALLY = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t state_q, state_d;

  // Arrays are sized to the full index range so that out-of-range indices
  // (which are always rejected) never address past the end.
  logic [CNT_W-1:0]      tally [2**CAND_W];
  logic [2**VOTER_W-1:0] used;
  logic [VOTER_W:0]      total_q;
  logic [CAND_W-1:0]     scan_idx;
  logic [CAND_W-1:0]     best_idx;
  logic [CNT_W-1:0]      best_cnt;
  logic                  tie_q;
  logic                  ack_q, nack_q;

  logic cand_ok, voter_ok, accept, start, last_scan;

  assign cand_ok   = 32'(vote_cand) < NUM_CAND;
  assign voter_ok  = 32'(voter_id) < NUM_VOTERS;
  assign accept    = (state_q == S_OPEN) && vote_valid && cand_ok && voter_ok
                     && !used[voter_id];
  assign last_scan = (scan_idx == CAND_W'(NUM_CAND - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (open_poll) begin
          state_d = S_OPEN;
          start   = 1'b1;
        end
      end
      S_OPEN: begin
        if (close_poll) state_d = S_TALLY;
      end
      S_TALLY: begin
        if (last_scan) state_d = S_DONE;
      end
      S_DONE: begin
        if (open_poll) begin
          state_d = S_OPEN;
          start   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**CAND_W; i++) tally[i] <= '0;
      used     <= '0;
      total_q  <= '0;
      scan_idx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
      tie_q    <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      ack_q  <= accept;
      nack_q <= vote_valid && !accept;

      if (start) begin
        for (int i = 0; i < 2**CAND_W; i++) tally[i] <= '0;
        used     <= '0;
        total_q  <= '0;
        best_idx <= '0;
        best_cnt <= '0;
        tie_q    <= 1'b0;
      end else if (accept) begin
        // Saturate the tally, but the vote still counts toward total_votes.
        if (tally[vote_cand] != {CNT_W{1'b1}})
          tally[vote_cand] <= tally[vote_cand] + 1'b1;
        used[voter_id] <= 1'b1;
        total_q        <= total_q + 1'b1;
      end

      if (state_q == S_OPEN && close_poll) scan_idx <= '0;

      if (state_q == S_TALLY) begin
        scan_idx <= scan_idx + 1'b1;
        // Index 0 seeds the running max; strict > keeps the lowest index on ties.
        if (scan_idx == '0 || tally[scan_idx] > best_cnt) begin
          best_cnt <= tally[scan_idx];
          best_idx <= scan_idx;
          tie_q    <= 1'b0;
        end else if (tally[scan_idx] == best_cnt) begin
          tie_q <= 1'b1;
        end
      end
    end
  end

  assign vote_ack     = ack_q;
  assign vote_nack    = nack_q;
  assign state        = state_q;
  assign winner       = best_idx;
  assign winner_valid = (state_q == S_DONE);
  assign tie          = tie_q && (state_q == S_DONE);
  assign total_votes  = total_q;

endmodule
